ser_tx: RTL and testbench
=========================

Name: ser_tx

Overview:
Parallel-in, serial-out frame transmitter. It is the transmit end of the team's single-wire serial link and the counterpart to the bit-serial receiver.
- Accepts one WIDTH-bit word per valid/ready handshake.
- Emits the word on `sout` as a framed bit stream: start bit, data bits `data[0]` first, optional even parity bit, stop bit.
- Sits between a word-producing datapath (register file or adder/subtractor result) and the serial line.

Parameters:
WIDTH, 8, number of data bits per frame (≥1).
CLKS_PER_BIT, 1, clock cycles each serial bit is held on `sout` (≥1).
PARITY, 0, 0 = no parity bit; 1 = even parity bit appended after the data bits.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
valid  input  1  producer has a word on `data`
data  input  [0:WIDTH-1]  word to send; `data[0]` is transmitted first
ready  output  1  transmitter can accept a word this cycle
sout  output  1  serial line; idles high
busy  output  1  frame in progress
done  output  1  one-cycle pulse when a frame's stop bit completes

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port `clk`, reset port `reset`.
- Reset values (after the edge with reset=1):
  - state=IDLE, sout=1, ready=1, busy=0, done=0.
  - Shift register = 0; bit counter = 0; clock-divider counter = 0.
- Reset wins over all other inputs.
  - Reset mid-frame aborts the frame. `sout` returns high at the next edge and no done pulse is produced.
- States: IDLE, START, DATA, PAR, STOP.
- ready = (state==IDLE); busy = (state!=IDLE). Both are registered-state decodes with no combinational path from `valid`.
- Handshake:
  - A transfer occurs on a rising edge where valid=1 and ready=1.
  - `data` is captured into the shift register at that edge.
  - `valid` is ignored when ready=0; `data` need not be held after the transfer.
- IDLE: sout=1. On transfer → START.
- START: sout=0 for CLKS_PER_BIT cycles → DATA.
- DATA: sout = current shift-register bit 0.
  - After each CLKS_PER_BIT cycles the register shifts toward index 0 and the bit counter increments.
  - After WIDTH bits → PAR if PARITY=1, else STOP.
- PAR: sout = XOR of the captured WIDTH bits (even parity: total ones including the parity bit is even), held CLKS_PER_BIT cycles → STOP.
  - The parity value is computed from the captured word, not the live `data` input.
- STOP: sout=1 for CLKS_PER_BIT cycles.
  - On the last STOP cycle's edge → IDLE and done=1 for exactly the following cycle.
- Latency: transfer at edge T → start bit visible on `sout` from T+1.
- Frame length: F = (2 + WIDTH + PARITY) × CLKS_PER_BIT cycles.
  - `ready` returns high in cycle T+F+1, which is the same cycle `done` is high.
- Back-to-back: a new transfer is accepted in the done cycle. The minimum line idle between frames is therefore 1 cycle (sout=1), giving a throughput of one word per F+1 cycles.
- Divider counter: counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary. With CLKS_PER_BIT=1 every state lasts one cycle per bit.
- Bit counter: width ⌈log2(WIDTH+1)⌉; cleared on entry to START.
- Constraint: all state elements are plain synchronous-reset flops (dfr/dfrl style), with no asynchronous paths.

Test Plan:
1. Basic frame, no parity.
   - Setup: WIDTH=8, CLKS=1, PARITY=0; reset, then valid=1 with data[0:7]=10110000.
   - Required: `sout` from T+1 = 0,1,0,1,1,0,0,0,0,1, then 1 idle. done=1 at T+11 only. ready=0 for T+1..T+10.
2. Even parity.
   - Setup: same data with PARITY=1.
   - Required: `sout` = 0,1,0,1,1,0,0,0,0,1(parity),1(stop). With data=11110000 the parity bit is 0.
3. Clock divider.
   - Setup: CLKS_PER_BIT=4, WIDTH=8, data=01010101.
   - Required: each bit is held exactly 4 cycles; frame is 40 cycles; done at T+41.
4. Back-to-back and ignored valid.
   - Setup: hold valid=1 continuously with data=FF then 00; also assert valid mid-frame.
   - Required: second frame's start bit at T+12 (exactly one idle-high cycle). No capture during busy.
5. Reset mid-frame.
   - Setup: assert reset during DATA bit 3 for one cycle.
   - Required: next cycle sout=1, ready=1, busy=0, no done pulse. A following transfer produces a clean full frame.

Source files
------------

// File: rtl/ser_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, data LSB (data[0]) first,
// optional even parity, stop bit. Line idles high; one word per valid/ready handshake.
module ser_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [0:WIDTH-1] data,
    output logic             ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic [DW-1:0]    r_div;
    logic             r_par;
    logic             r_sout;
    logic             r_done;

    logic [WIDTH-1:0] w_cap;
    logic [WIDTH-1:0] w_shift_nxt;
    logic             w_cap_par;
    logic             w_tick;
    logic             w_last_bit;

    // Shift register holds data[i] at bit i so bit 0 is always the next bit out.
    always_comb begin
        w_cap = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_cap[i] = data[i];
        end
        w_cap_par = ^data;
    end

    assign w_shift_nxt = r_shift >> 1;
    assign w_tick      = (r_div == DW'(CLKS_PER_BIT - 1));
    assign w_last_bit  = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_div   <= '0;
            r_par   <= 1'b0;
            r_sout  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != IDLE) begin
                r_div <= w_tick ? '0 : r_div + DW'(1);
            end
            case (r_state)
                IDLE: begin
                    r_sout <= 1'b1;
                    if (valid) begin
                        r_shift <= w_cap;
                        r_par   <= w_cap_par;
                        r_cnt   <= '0;
                        r_div   <= '0;
                        r_sout  <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_sout  <= r_shift[0];
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift <= w_shift_nxt;
                        r_cnt   <= r_cnt + CW'(1);
                        if (w_last_bit) begin
                            if (PARITY != 0) begin
                                r_sout  <= r_par;
                                r_state <= PAR;
                            end else begin
                                r_sout  <= 1'b1;
                                r_state <= STOP;
                            end
                        end else begin
                            r_sout <= w_shift_nxt[0];
                        end
                    end
                end
                PAR: begin
                    if (w_tick) begin
                        r_sout  <= 1'b1;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_sout  <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready = (r_state == IDLE);
    assign busy  = (r_state != IDLE);
    assign sout  = r_sout;
    assign done  = r_done;

endmodule

// File: tb/tb_ser_tx.sv
// Directed bench for ser_tx: three instances cover plain, even-parity and
// divided-clock configurations; expected line sequences are hand-derived.
module tb_ser_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic [0:7] d0 = '0, d1 = '0, d2 = '0;
    logic       r0, s0, b0, dn0;
    logic       r1, s1, b1, dn1;
    logic       r2, s2, b2, dn2;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    ser_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY(0)) u0 (
        .clk(clk), .reset(reset), .valid(v0), .data(d0),
        .ready(r0), .sout(s0), .busy(b0), .done(dn0)
    );
    ser_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY(1)) u1 (
        .clk(clk), .reset(reset), .valid(v1), .data(d1),
        .ready(r1), .sout(s1), .busy(b1), .done(dn1)
    );
    ser_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(0)) u2 (
        .clk(clk), .reset(reset), .valid(v2), .data(d2),
        .ready(r2), .sout(s2), .busy(b2), .done(dn2)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        checks++;
        if ({s0, r0, b0, dn0} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_u0 got sout,ready,busy,done=%b exp 1100", {s0, r0, b0, dn0});
        end
        checks++;
        if ({s1, r1, b1, dn1} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_u1 got sout,ready,busy,done=%b exp 1100", {s1, r1, b1, dn1});
        end
        checks++;
        if ({s2, r2, b2, dn2} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_u2 got sout,ready,busy,done=%b exp 1100", {s2, r2, b2, dn2});
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        logic [0:9] e;
        e  = 10'b0_10110000_1;
        d0 = 8'b10110000;
        v0 = 1'b1;
        tick;
        v0 = 1'b0;
        d0 = '0;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (s0 !== e[k]) begin
                errors++;
                $display("FAIL basic_sout T+%0d got %b exp %b", k + 1, s0, e[k]);
            end
            checks++;
            if ({r0, b0, dn0} !== 3'b010) begin
                errors++;
                $display("FAIL basic_flags T+%0d got ready,busy,done=%b exp 010", k + 1, {r0, b0, dn0});
            end
            tick;
        end
        checks++;
        if ({s0, r0, b0, dn0} !== 4'b1101) begin
            errors++;
            $display("FAIL basic_done got sout,ready,busy,done=%b exp 1101", {s0, r0, b0, dn0});
        end
        tick;
        checks++;
        if ({s0, r0, dn0} !== 3'b110) begin
            errors++;
            $display("FAIL basic_after got sout,ready,done=%b exp 110", {s0, r0, dn0});
        end
    endtask

    task automatic test_parity;
        logic [0:10] e;
        logic [0:7]  w;
        for (int f = 0; f < 2; f++) begin
            if (f == 0) begin
                w = 8'b10110000;
                e = 11'b0_10110000_1_1;
            end else begin
                w = 8'b11110000;
                e = 11'b0_11110000_0_1;
            end
            d1 = w;
            v1 = 1'b1;
            tick;
            v1 = 1'b0;
            d1 = ~w;
            for (int k = 0; k < 11; k++) begin
                checks++;
                if (s1 !== e[k] || dn1 !== 1'b0) begin
                    errors++;
                    $display("FAIL parity_f%0d T+%0d got sout=%b done=%b exp sout=%b done=0",
                             f, k + 1, s1, dn1, e[k]);
                end
                tick;
            end
            checks++;
            if ({s1, r1, dn1} !== 3'b111) begin
                errors++;
                $display("FAIL parity_done_f%0d got sout,ready,done=%b exp 111", f, {s1, r1, dn1});
            end
            tick;
        end
    endtask

    task automatic test_divider;
        logic [0:9] e;
        e  = 10'b0_01010101_1;
        d2 = 8'b01010101;
        v2 = 1'b1;
        tick;
        v2 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (s2 !== e[k/4] || r2 !== 1'b0 || dn2 !== 1'b0) begin
                errors++;
                $display("FAIL div_sout T+%0d got sout=%b ready=%b done=%b exp sout=%b ready=0 done=0",
                         k + 1, s2, r2, dn2, e[k/4]);
            end
            tick;
        end
        checks++;
        if ({s2, r2, dn2} !== 3'b111) begin
            errors++;
            $display("FAIL div_done T+41 got sout,ready,done=%b exp 111", {s2, r2, dn2});
        end
        tick;
        checks++;
        if (dn2 !== 1'b0) begin
            errors++;
            $display("FAIL div_done_pulse T+42 got done=%b exp 0", dn2);
        end
    endtask

    task automatic test_back_to_back;
        logic [0:9] e1;
        logic [0:9] e2;
        e1 = 10'b0_11111111_1;
        e2 = 10'b0_00000000_1;
        d0 = 8'hFF;
        v0 = 1'b1;
        tick;
        d0 = 8'h00;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (s0 !== e1[k] || r0 !== 1'b0) begin
                errors++;
                $display("FAIL b2b_f1 T+%0d got sout=%b ready=%b exp sout=%b ready=0", k + 1, s0, r0, e1[k]);
            end
            tick;
        end
        checks++;
        if ({s0, r0, dn0} !== 3'b111) begin
            errors++;
            $display("FAIL b2b_gap T+11 got sout,ready,done=%b exp 111", {s0, r0, dn0});
        end
        tick;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (s0 !== e2[k] || r0 !== 1'b0) begin
                errors++;
                $display("FAIL b2b_f2 T+%0d got sout=%b ready=%b exp sout=%b ready=0", k + 12, s0, r0, e2[k]);
            end
            if (k == 9) v0 = 1'b0;
            tick;
        end
        checks++;
        if ({s0, r0, dn0} !== 3'b111) begin
            errors++;
            $display("FAIL b2b_done2 T+22 got sout,ready,done=%b exp 111", {s0, r0, dn0});
        end
        tick;
        checks++;
        if ({s0, r0, b0, dn0} !== 4'b1100) begin
            errors++;
            $display("FAIL b2b_idle T+23 got sout,ready,busy,done=%b exp 1100", {s0, r0, b0, dn0});
        end
    endtask

    task automatic test_reset_mid;
        logic [0:9] e;
        d0 = 8'b11111111;
        v0 = 1'b1;
        tick;
        v0 = 1'b0;
        // Cycles T+1..T+4: start, bits 0..2; reset is asserted during bit 3 (T+5).
        for (int k = 0; k < 4; k++) tick;
        checks++;
        if (s0 !== 1'b1 || b0 !== 1'b1) begin
            errors++;
            $display("FAIL rmid_bit3 got sout=%b busy=%b exp sout=1 busy=1", s0, b0);
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++;
        if ({s0, r0, b0, dn0} !== 4'b1100) begin
            errors++;
            $display("FAIL rmid_abort got sout,ready,busy,done=%b exp 1100", {s0, r0, b0, dn0});
        end
        for (int k = 0; k < 8; k++) begin
            tick;
            checks++;
            if (dn0 !== 1'b0 || s0 !== 1'b1) begin
                errors++;
                $display("FAIL rmid_nodone cycle %0d got done=%b sout=%b exp done=0 sout=1", k, dn0, s0);
            end
        end
        e  = 10'b0_11001010_1;
        d0 = 8'b11001010;
        v0 = 1'b1;
        tick;
        v0 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (s0 !== e[k]) begin
                errors++;
                $display("FAIL rmid_frame T+%0d got %b exp %b", k + 1, s0, e[k]);
            end
            tick;
        end
        checks++;
        if ({s0, r0, dn0} !== 3'b111) begin
            errors++;
            $display("FAIL rmid_done got sout,ready,done=%b exp 111", {s0, r0, dn0});
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_divider;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
